// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer: FSM state encoding, stage strobe
// indices and the state-to-strobe decode used by the control unit and benches.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IF     = 3'd1,
    S_ID     = 3'd2,
    S_ALU    = 3'd3,
    S_MEM    = 3'd4,
    S_RB_BR  = 3'd5,
    S_INT    = 3'd6,
    S_HALTED = 3'd7
  } seq_state_e;

  localparam int NUM_STAGES  = 5;
  localparam int STAGE_IF    = 0;
  localparam int STAGE_ID    = 1;
  localparam int STAGE_ALU   = 2;
  localparam int STAGE_MEM   = 3;
  localparam int STAGE_RB_BR = 4;

  localparam int WAIT_W = 8;

  function automatic logic [NUM_STAGES-1:0] stage_strobes(input seq_state_e st);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    case (st)
      S_IF:    v[STAGE_IF]    = 1'b1;
      S_ID:    v[STAGE_ID]    = 1'b1;
      S_ALU:   v[STAGE_ALU]   = 1'b1;
      S_MEM:   v[STAGE_MEM]   = 1'b1;
      S_RB_BR: v[STAGE_RB_BR] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// MEM-phase wait counter: synchronous clear/enable counter with a terminal-count
// flag raised when the count equals MEM_WAIT_MAX.
module stage_sequencer_mem_wait_timer
  import stage_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              tc
);

  localparam logic [WAIT_W-1:0] TC_VAL = WAIT_W'(MEM_WAIT_MAX);

  logic [WAIT_W-1:0] wait_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q;

  // next count: clear has priority over increment
  always_comb begin
    if (clr) begin
      wait_cnt_d = '0;
    end else if (en) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt = wait_cnt_q;
  assign tc       = (wait_cnt_q == TC_VAL);

endmodule

// File: rtl/stage_sequencer.sv
// Five-phase instruction stage sequencer with MEM stretching, HLT parking and
// MTC interrupt hold-off. Define SEQ_SKIP_MEM_EN to bypass MEM for non-memory instructions.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             interrupt,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             int_done,
  output logic             IF_en,
  output logic             ID_en,
  output logic             ALU_en,
  output logic             MEM_en,
  output logic             RB_BR_en,
  output logic             int_ack,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_e             state_d, state_q;
  logic                   int_pend_d, int_pend_q;
  logic [CNT_W-1:0]       instr_count_d, instr_count_q;
  logic [NUM_STAGES-1:0]  strobes_d, strobes_q;
  logic                   int_ack_d, int_ack_q;
  logic                   halted_d, halted_q;
  logic                   mem_exit_s;
  logic                   mem_timeout_s;
  logic                   timer_clr_s;
  logic                   timer_en_s;
  logic [WAIT_W-1:0]      wait_cnt_s;
  logic                   wait_tc_s;

  stage_sequencer_mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr_s),
    .en       (timer_en_s),
    .wait_cnt (wait_cnt_s),
    .tc       (wait_tc_s)
  );

  // next-state, pending-interrupt and retired-count logic
  always_comb begin
    state_d       = state_q;
    int_pend_d    = int_pend_q;
    instr_count_d = instr_count_q;
    mem_exit_s    = 1'b0;
    mem_timeout_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_IF;
        else       state_d = S_IDLE;
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        state_d = S_ALU;
        if (interrupt) int_pend_d = 1'b1;
        else           int_pend_d = int_pend_q;
      end
      S_ALU: begin
        if (halt) begin
          state_d       = S_HALTED;
          instr_count_d = instr_count_q + CNT_W'(1);
          int_pend_d    = 1'b0;
        end
`ifdef SEQ_SKIP_MEM_EN
        else if (!mem_access) begin
          state_d = S_RB_BR;
        end
`endif
        else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        // ready is checked before the terminal count so a same-cycle ready suppresses the timeout
        if (!mem_access || mem_ready) begin
          mem_exit_s = 1'b1;
          state_d    = S_RB_BR;
        end else if (wait_tc_s) begin
          mem_exit_s    = 1'b1;
          mem_timeout_s = 1'b1;
          state_d       = S_RB_BR;
        end else begin
          state_d = S_MEM;
        end
      end
      S_RB_BR: begin
        instr_count_d = instr_count_q + CNT_W'(1);
        if (int_pend_q) state_d = S_INT;
        else            state_d = S_IF;
      end
      S_INT: begin
        if (int_done) begin
          int_pend_d = 1'b0;
          state_d    = S_IF;
        end else begin
          state_d = S_INT;
        end
      end
      S_HALTED: begin
        if (start) state_d = S_IF;
        else       state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs precomputed from the next state so the flops line up with state_q
  always_comb begin
    strobes_d = stage_strobes(state_d);
    int_ack_d = (state_d == S_INT);
    halted_d  = (state_d == S_HALTED);
  end

  // wait counter runs only while MEM is held; it never wraps past all-ones
  always_comb begin
    timer_en_s  = (state_q == S_MEM) && !mem_exit_s && (wait_cnt_s != {WAIT_W{1'b1}});
    timer_clr_s = (state_q != S_MEM) || mem_exit_s;
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      int_pend_q    <= 1'b0;
      instr_count_q <= '0;
      strobes_q     <= '0;
      int_ack_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pend_q    <= int_pend_d;
      instr_count_q <= instr_count_d;
      strobes_q     <= strobes_d;
      int_ack_q     <= int_ack_d;
      halted_q      <= halted_d;
    end
  end

  assign IF_en       = strobes_q[STAGE_IF];
  assign ID_en       = strobes_q[STAGE_ID];
  assign ALU_en      = strobes_q[STAGE_ALU];
  assign MEM_en      = strobes_q[STAGE_MEM];
  assign RB_BR_en    = strobes_q[STAGE_RB_BR];
  assign int_ack     = int_ack_q;
  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_s;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: instruction-level plans expanded into per-cycle
// phase expectations, with random noise on every input the current phase ignores.
module tb_stage_sequencer;

  localparam int WMAX = 15;
`ifdef SEQ_SKIP_MEM_EN
  localparam bit SKIP_MEM = 1'b1;
`else
  localparam bit SKIP_MEM = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_IF = 1, PH_ID = 2, PH_ALU = 3;
  localparam int PH_MEM = 4, PH_RB = 5, PH_INT = 6, PH_HALT = 7;

  typedef struct {
    int          ph;
    bit          strt, intr, hlt, macc, rdy, done, tmo;
    logic [31:0] cnt;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst, start, halt, interrupt, mem_access, mem_ready, int_done;
  logic        IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, int_ack, halted, mem_timeout;
  logic [31:0] instr_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  cyc_t        exp_q[$];
  logic [31:0] model_cnt;

  stage_sequencer #(.CNT_W(32), .MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .interrupt(interrupt),
    .mem_access(mem_access), .mem_ready(mem_ready), .int_done(int_done),
    .IF_en(IF_en), .ID_en(ID_en), .ALU_en(ALU_en), .MEM_en(MEM_en),
    .RB_BR_en(RB_BR_en), .int_ack(int_ack), .halted(halted),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return ($urandom() & 32'd1) != 32'd0;
  endfunction

  function automatic void push(int ph, bit strt, bit intr, bit hlt, bit macc, bit rdy, bit done, bit tmo);
    cyc_t c;
    c.ph = ph; c.strt = strt; c.intr = intr; c.hlt = hlt; c.macc = macc;
    c.rdy = rdy; c.done = done; c.tmo = tmo; c.cnt = model_cnt;
    exp_q.push_back(c);
  endfunction

  // n cycles parked in IDLE or HALTED; if go, start is raised on the last one
  function automatic void plan_wait(int ph, int n, bit go);
    for (int i = 0; i < n; i++) push(ph, go && (i == n - 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // one instruction: ready arrives in MEM cycle rdy_dly+1, int_done in INT cycle done_dly+1
  function automatic void plan_instr(bit mem, int rdy_dly, bit intr, bit hlt, int done_dly);
    push(PH_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(PH_ID, 1'b0, intr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(PH_ALU, 1'b0, 1'b0, hlt, mem, 1'b0, 1'b0, 1'b0);
    if (hlt) begin
      model_cnt = model_cnt + 32'd1;
      return;
    end
    if (!mem && !SKIP_MEM) begin
      push(PH_MEM, 1'b0, 1'b0, 1'b0, 1'b0, rbit(), 1'b0, 1'b0);
    end else if (mem) begin
      for (int i = 0; i <= WMAX; i++) begin
        if (i == rdy_dly) begin
          push(PH_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
          break;
        end else if (i == WMAX) begin
          push(PH_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
          break;
        end else begin
          push(PH_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
      end
    end
    push(PH_RB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_cnt = model_cnt + 32'd1;
    if (intr) begin
      for (int j = 0; j <= done_dly; j++) push(PH_INT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, j == done_dly, 1'b0);
    end
  endfunction

  // {IF, ID, ALU, MEM, RB_BR, int_ack, halted, mem_timeout}
  function automatic logic [7:0] exp_vec(cyc_t c);
    logic [7:0] v;
    v = 8'd0;
    case (c.ph)
      PH_IF:   v[7] = 1'b1;
      PH_ID:   v[6] = 1'b1;
      PH_ALU:  v[5] = 1'b1;
      PH_MEM:  v[4] = 1'b1;
      PH_RB:   v[3] = 1'b1;
      PH_INT:  v[2] = 1'b1;
      PH_HALT: v[1] = 1'b1;
      default: v = 8'd0;
    endcase
    v[0] = c.tmo;
    return v;
  endfunction

  task automatic step(input cyc_t c, output logic [7:0] obs, output logic [31:0] cnt);
    @(negedge clk);
    start      = (c.ph == PH_IDLE || c.ph == PH_HALT) ? c.strt : rbit();
    interrupt  = (c.ph == PH_ID) ? c.intr : rbit();
    halt       = (c.ph == PH_ALU) ? c.hlt : rbit();
    mem_access = (c.ph == PH_ALU || c.ph == PH_MEM) ? c.macc : rbit();
    mem_ready  = (c.ph == PH_MEM) ? c.rdy : rbit();
    int_done   = (c.ph == PH_INT) ? c.done : rbit();
    #1;
    obs = {IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, int_ack, halted, mem_timeout};
    cnt = instr_count;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = rbit(); halt = rbit(); interrupt = rbit();
    mem_access = rbit(); mem_ready = rbit(); int_done = rbit();
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    model_cnt = 32'd0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt;
    rst = 1'b1; start = 1'b1; halt = 1'b1; interrupt = 1'b1;
    mem_access = 1'b1; mem_ready = 1'b0; int_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if ({IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, int_ack, halted, mem_timeout} !== 8'd0) begin
      n_bad++; $display("FAIL reset outputs: got %b want 00000000", {IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, int_ack, halted, mem_timeout});
    end
    n_cmp++;
    if (instr_count !== 32'd0) begin n_bad++; $display("FAIL reset count: got %0d want 0", instr_count); end
    rst = 1'b0; start = 1'b0;
    model_cnt = 32'd0;
    plan_wait(PH_IDLE, 3, 1'b0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL idle strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL idle count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  task automatic test_basic();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt;
    do_reset();
    plan_wait(PH_IDLE, 2, 1'b1);
    plan_instr(1'b0, 0, 1'b0, 1'b0, 0);
    plan_instr(1'b0, 0, 1'b0, 1'b0, 0);
    plan_instr(1'b1, 0, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL basic strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL basic count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  task automatic test_mem_wait();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt;
    do_reset();
    plan_wait(PH_IDLE, 1, 1'b1);
    plan_instr(1'b1, 3, 1'b0, 1'b0, 0);
    plan_instr(1'b1, 1000, 1'b0, 1'b0, 0);
    plan_instr(1'b1, WMAX, 1'b0, 1'b0, 0);
    plan_instr(1'b1, WMAX - 1, 1'b0, 1'b0, 0);
    plan_instr(1'b0, 0, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL memwait strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL memwait count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  task automatic test_interrupt();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt;
    do_reset();
    plan_wait(PH_IDLE, 1, 1'b1);
    plan_instr(1'b0, 0, 1'b1, 1'b0, 2);
    plan_instr(1'b1, 2, 1'b1, 1'b0, 0);
    plan_instr(1'b0, 0, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL interrupt strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL interrupt count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  task automatic test_halt();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt;
    do_reset();
    plan_wait(PH_IDLE, 1, 1'b1);
    plan_instr(1'b0, 0, 1'b1, 1'b1, 0);
    plan_wait(PH_HALT, 4, 1'b1);
    plan_instr(1'b0, 0, 1'b0, 1'b0, 0);
    plan_instr(1'b1, 0, 1'b0, 1'b1, 0);
    plan_wait(PH_HALT, 1, 1'b1);
    plan_instr(1'b0, 0, 1'b1, 1'b0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL halt strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL halt count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt; int n_run;
    do_reset();
    plan_wait(PH_IDLE, 1, 1'b1);
    plan_instr(1'b0, 0, 1'b1, 1'b0, 1);
    n_run = exp_q.size() + 3 + 5;
    plan_instr(1'b1, 1000, 1'b1, 1'b0, 0);
    for (int k = 0; k < n_run; k++) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL midrst strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL midrst count: got %0d want %0d", cnt, c.cnt); end
    end
    do_reset();
    @(negedge clk); #1;
    n_cmp++;
    if ({IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, int_ack, halted, mem_timeout} !== 8'd0) begin
      n_bad++; $display("FAIL midrst outputs: got %b want 00000000", {IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, int_ack, halted, mem_timeout});
    end
    n_cmp++;
    if (instr_count !== 32'd0) begin n_bad++; $display("FAIL midrst cleared count: got %0d want 0", instr_count); end
    plan_wait(PH_IDLE, 1, 1'b1);
    plan_instr(1'b0, 0, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL postrst strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL postrst count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  task automatic test_random();
    cyc_t c; logic [7:0] obs; logic [31:0] cnt; bit hlt;
    do_reset();
    plan_wait(PH_IDLE, int'($urandom_range(1, 3)), 1'b1);
    for (int n = 0; n < 40; n++) begin
      hlt = ($urandom_range(0, 5) == 0);
      plan_instr(rbit(), int'($urandom_range(0, 18)), rbit(), hlt, int'($urandom_range(0, 3)));
      if (hlt) plan_wait(PH_HALT, int'($urandom_range(1, 3)), 1'b1);
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); step(c, obs, cnt);
      n_cmp++;
      if (obs !== exp_vec(c)) begin n_bad++; $display("FAIL random strobes: got %b want %b", obs, exp_vec(c)); end
      n_cmp++;
      if (cnt !== c.cnt) begin n_bad++; $display("FAIL random count: got %0d want %0d", cnt, c.cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_interrupt();
    test_halt();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
